// File: rtl/tx_pkg.sv
// tx_pkg: shared write-FSM type and sizing/pattern helpers for the TX segment buffer
package tx_pkg;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_HOLD} w_state_t;
  function automatic int bank_bytes(input int seg_bytes, input int seg_max);
    return seg_bytes * seg_max;
  endfunction
  function automatic int addr_width(input int seg_bytes, input int seg_max);
    return $clog2(2 * seg_bytes * seg_max);
  endfunction
  function automatic logic [7:0] testpat(input logic [7:0] seg, input logic [7:0] ctr);
    return seg ^ ctr;
  endfunction
endpackage

// File: rtl/tx_pixel_serializer.sv
// tx_pixel_serializer: splits a loaded pixel word into MSB-first byte writes
module tx_pixel_serializer #(
  parameter int PIX_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [8*PIX_BYTES-1:0] word,
  output logic                   busy,
  output logic                   we,
  output logic [7:0]             wbyte
);
  localparam int CW = $clog2(PIX_BYTES + 1);
  logic [8*PIX_BYTES-1:0] sh;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
    end else if (load) begin
      sh <= word;
      cnt <= CW'(PIX_BYTES);
    end else if (busy) begin
      sh <= sh << 8;
      cnt <= cnt - 1'b1;
    end
  always_comb begin
    busy = cnt != '0;
    we = busy;
    wbyte = sh[8*PIX_BYTES-1 -: 8];
  end
endmodule

// File: rtl/tx_segment_buffer.sv
// tx_segment_buffer: ping-pong frame banks feeding segment payload bytes to byte_data
module tx_segment_buffer
  import tx_pkg::*;
#(
  parameter int PIX_BYTES          = 3,
  parameter int SEG_BYTES          = 960,
  parameter int SEGMENT_NUMBER_MAX = 720
) (
  input  logic                   clk125MHz,
  input  logic                   rst,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [8*PIX_BYTES-1:0] pix_data,
  input  logic                   pix_sof,
  input  logic                   hdmimode,
  input  logic [15:0]            segment_num,
  input  logic [7:0]             txid,
  input  logic [7:0]             redundancy,
  input  logic [11:0]            byte_data_counter,
  input  logic                   data_user,
  output logic [23:0]            startaddr,
  output logic [7:0]             doutb,
  output logic                   oneframe_done,
  output logic                   maxdetect,
  output logic                   frame_ready,
  output logic [7:0]             drop_count
);
  localparam int BANK_BYTES = bank_bytes(SEG_BYTES, SEGMENT_NUMBER_MAX);
  localparam int AW = addr_width(SEG_BYTES, SEGMENT_NUMBER_MAX);
  localparam logic [AW-1:0] BANK_BASE = AW'(BANK_BYTES);
  localparam logic [AW-1:0] LAST_OFF = AW'(BANK_BYTES - 1);
  localparam logic [15:0] SEG_LAST = 16'(SEGMENT_NUMBER_MAX - 1);
  w_state_t state, state_nx;
  logic wr_bank, armed, done_pend, du_d, busy, ser_we, ld, acc, sof_acc, wr_en, fill_last, swap, tx_valid;
  logic [7:0] wbyte, red_last;
  logic [7:0] mem [2*BANK_BYTES];
  logic [AW-1:0] wr_off, waddr, raddr, rd_base, sa_nx;
  tx_pixel_serializer #(.PIX_BYTES(PIX_BYTES)) u_ser (
    .clk(clk125MHz),
    .rst(rst),
    .load(ld),
    .word(pix_data),
    .busy(busy),
    .we(ser_we),
    .wbyte(wbyte)
  );
  always_comb begin
    pix_ready = armed & ((state != W_FILL) | ~busy);
    acc = pix_valid & pix_ready;
    sof_acc = acc & pix_sof;
    ld = state == W_FILL ? acc : sof_acc;
    wr_en = ser_we & (state == W_FILL);
    fill_last = wr_en & (wr_off == LAST_OFF);
    swap = (state == W_HOLD) & (oneframe_done | done_pend | ~frame_ready);
    state_nx = state == W_IDLE ? (sof_acc ? W_FILL : W_IDLE)
             : state == W_FILL ? (fill_last ? W_HOLD : W_FILL)
             : sof_acc ? W_FILL : swap ? W_IDLE : W_HOLD;
    waddr = (wr_bank ? BANK_BASE : '0) + wr_off;
    rd_base = wr_bank ? '0 : BANK_BASE;
    sa_nx = rd_base + AW'(segment_num) * AW'(SEG_BYTES);
    raddr = startaddr[AW-1:0] + AW'(byte_data_counter);
    tx_valid = data_user & (byte_data_counter < 12'(SEG_BYTES))
             & (segment_num < 16'(SEGMENT_NUMBER_MAX)) & frame_ready;
    red_last = (redundancy == 8'd0 ? 8'd1 : redundancy) - 8'd1;
  end
  always_ff @(posedge clk125MHz)
    if (rst) begin
      state <= W_IDLE;
      wr_bank <= 1'b0;
      wr_off <= '0;
      armed <= 1'b0;
      done_pend <= 1'b0;
      du_d <= 1'b0;
      frame_ready <= 1'b0;
      drop_count <= '0;
      startaddr <= '0;
      doutb <= '0;
      oneframe_done <= 1'b0;
      maxdetect <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      du_d <= data_user;
      done_pend <= oneframe_done & fill_last;
      if (swap) begin
        wr_bank <= ~wr_bank;
        frame_ready <= 1'b1;
      end
      if (sof_acc) wr_off <= '0;
      else if (wr_en) wr_off <= wr_off + 1'b1;
      if (sof_acc & ((state == W_FILL) | ((state == W_HOLD) & ~swap)) & (drop_count != 8'hff))
        drop_count <= drop_count + 1'b1;
      startaddr <= 24'(sa_nx);
      maxdetect <= segment_num == SEG_LAST;
      oneframe_done <= du_d & ~data_user & (segment_num == SEG_LAST) & (txid == red_last);
      doutb <= ~hdmimode ? (data_user ? testpat(segment_num[7:0], byte_data_counter[7:0]) : 8'd0)
             : tx_valid ? mem[raddr] : 8'd0;
    end
  always_ff @(posedge clk125MHz)
    if (wr_en) mem[waddr] <= wbyte;
endmodule

// File: tb/tb_tx_segment_buffer.sv
// tb_tx_segment_buffer: vector-table and scoreboard checks of tx_segment_buffer
module tb_tx_segment_buffer;
  logic clk125MHz = 1'b0, rst = 1'b1, pix_valid = 1'b0, pix_sof = 1'b0, hdmimode = 1'b1, data_user = 1'b0;
  logic pix_ready, oneframe_done, maxdetect, frame_ready;
  logic [23:0] pix_data = '0;
  logic [15:0] segment_num = '0;
  logic [7:0] txid = '0, redundancy = 8'd2;
  logic [11:0] byte_data_counter = '0;
  logic [23:0] startaddr;
  logic [7:0] doutb, drop_count;
  int checks = 0, errors = 0;
  logic [7:0] m_frame [12];
  logic m_ready = 1'b0;
  logic [7:0] exp_q [$];
  typedef struct {
    int seg;
    int ctr;
    logic du;
    logic hdm;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [10];
  tx_segment_buffer #(.PIX_BYTES(3), .SEG_BYTES(4), .SEGMENT_NUMBER_MAX(3)) dut (
    .clk125MHz(clk125MHz),
    .rst(rst),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_sof(pix_sof),
    .hdmimode(hdmimode),
    .segment_num(segment_num),
    .txid(txid),
    .redundancy(redundancy),
    .byte_data_counter(byte_data_counter),
    .data_user(data_user),
    .startaddr(startaddr),
    .doutb(doutb),
    .oneframe_done(oneframe_done),
    .maxdetect(maxdetect),
    .frame_ready(frame_ready),
    .drop_count(drop_count)
  );
  always #4 clk125MHz = ~clk125MHz;
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask
  function automatic logic [7:0] exp_byte(input int s, input int c, input logic du, input logic h);
    if (!du) return 8'd0;
    if (!h) return 8'(s ^ c);
    return (c < 4 && s < 3 && m_ready) ? m_frame[s*4+c] : 8'd0;
  endfunction
  task automatic step(input logic [7:0] e);
    exp_q.push_back(e);
    @(negedge clk125MHz);
    chk("doutb", {24'd0, doutb}, {24'd0, exp_q.pop_front()});
  endtask
  task automatic idle(input int n);
    data_user = 1'b0;
    repeat (n) step(8'd0);
  endtask
  task automatic rd(input int s, input int c, input logic h);
    segment_num = 16'(s);
    data_user = 1'b0;
    hdmimode = h;
    step(8'd0);
    byte_data_counter = 12'(c);
    data_user = 1'b1;
    step(exp_byte(s, c, 1'b1, h));
    data_user = 1'b0;
  endtask
  task automatic send_pix(input logic [23:0] d, input logic s);
    int n = 0;
    pix_valid = 1'b1;
    pix_data = d;
    pix_sof = s;
    while (!pix_ready && n < 20) begin
      @(negedge clk125MHz);
      n++;
    end
    chk("pix_ready_wait", {31'd0, pix_ready}, 32'd1);
    @(negedge clk125MHz);
    pix_valid = 1'b0;
    pix_sof = 1'b0;
  endtask
  task automatic send_frame(input int base);
    for (int p = 0; p < 4; p++)
      send_pix({8'(base + 3*p), 8'(base + 3*p + 1), 8'(base + 3*p + 2)}, p == 0);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!frame_ready && n < 40) begin
      @(negedge clk125MHz);
      n++;
    end
    chk("frame_ready_wait", {31'd0, frame_ready}, 32'd1);
  endtask
  task automatic set_model(input int base);
    for (int i = 0; i < 12; i++) m_frame[i] = 8'(base + i);
    m_ready = 1'b1;
  endtask
  task automatic sweep();
    for (int t = 0; t < 2; t++)
      for (int s = 0; s < 3; s++) begin
        txid = 8'(t);
        segment_num = 16'(s);
        data_user = 1'b0;
        step(8'd0);
        for (int c = 0; c < 4; c++) begin
          byte_data_counter = 12'(c);
          data_user = 1'b1;
          step(exp_byte(s, c, 1'b1, 1'b1));
        end
        data_user = 1'b0;
        step(8'd0);
        chk("oneframe_done", {31'd0, oneframe_done}, {31'd0, (s == 2 && t == 1)});
        chk("maxdetect", {31'd0, maxdetect}, {31'd0, (s == 2)});
      end
    txid = 8'd0;
  endtask
  initial begin
    vt[0] = '{1, 0, 1'b1, 1'b1, 8'h05};
    vt[1] = '{0, 0, 1'b1, 1'b1, 8'h01};
    vt[2] = '{2, 3, 1'b1, 1'b1, 8'h0C};
    vt[3] = '{1, 3, 1'b1, 1'b1, 8'h08};
    vt[4] = '{1, 4, 1'b1, 1'b1, 8'h00};
    vt[5] = '{3, 0, 1'b1, 1'b1, 8'h00};
    vt[6] = '{1, 2, 1'b0, 1'b1, 8'h00};
    vt[7] = '{5, 3, 1'b1, 1'b0, 8'h06};
    vt[8] = '{2, 1, 1'b1, 1'b0, 8'h03};
    vt[9] = '{0, 4, 1'b1, 1'b0, 8'h04};
    repeat (3) @(negedge clk125MHz);
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
    chk("rst_doutb", {24'd0, doutb}, 32'd0);
    chk("rst_startaddr", {8'd0, startaddr}, 32'd0);
    chk("rst_oneframe_done", {31'd0, oneframe_done}, 32'd0);
    chk("rst_maxdetect", {31'd0, maxdetect}, 32'd0);
    rst = 1'b0;
    @(negedge clk125MHz);
    chk("pix_ready_armed", {31'd0, pix_ready}, 32'd1);
    chk("startaddr_bank1", {8'd0, startaddr}, 32'd12);
    rd(0, 0, 1'b1);
    send_frame(1);
    wait_ready();
    set_model(1);
    for (int i = 0; i < 10; i++) begin
      segment_num = 16'(vt[i].seg);
      hdmimode = vt[i].hdm;
      data_user = 1'b0;
      step(8'd0);
      byte_data_counter = 12'(vt[i].ctr);
      data_user = vt[i].du;
      step(vt[i].exp);
      data_user = 1'b0;
    end
    hdmimode = 1'b1;
    rd(1, 0, 1'b1);
    chk("startaddr_seg1", {8'd0, startaddr}, 32'd4);
    sweep();
    idle(1);
    chk("oneframe_done_pulse", {31'd0, oneframe_done}, 32'd0);
    idle(2);
    rd(0, 0, 1'b1);
    send_frame(8'h20);
    idle(4);
    chk("frame_ready_hold", {31'd0, frame_ready}, 32'd1);
    rd(0, 0, 1'b1);
    rd(2, 3, 1'b1);
    sweep();
    idle(3);
    set_model(8'h20);
    rd(0, 0, 1'b1);
    rd(2, 3, 1'b1);
    send_frame(8'h30);
    idle(4);
    chk("drop_none", {24'd0, drop_count}, 32'd0);
    rd(0, 0, 1'b1);
    send_pix(24'h0, 1'b1);
    chk("drop_one", {24'd0, drop_count}, 32'd1);
    repeat (299) send_pix(24'h0, 1'b1);
    chk("drop_sat", {24'd0, drop_count}, 32'd255);
    rd(1, 1, 1'b1);
    send_pix(24'h414243, 1'b1);
    send_pix(24'h444546, 1'b0);
    rst = 1'b1;
    @(negedge clk125MHz);
    chk("midrst_frame_ready", {31'd0, frame_ready}, 32'd0);
    chk("midrst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("midrst_drop", {24'd0, drop_count}, 32'd0);
    m_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk125MHz);
    chk("midrst_pix_ready_back", {31'd0, pix_ready}, 32'd1);
    for (int p = 0; p < 4; p++) send_pix(24'h515253 + 24'(p), 1'b0);
    idle(4);
    chk("nosof_frame_ready", {31'd0, frame_ready}, 32'd0);
    rd(0, 0, 1'b1);
    send_frame(8'h61);
    wait_ready();
    set_model(8'h61);
    rd(0, 0, 1'b1);
    rd(1, 2, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
